// File: rtl/sdram_stream_master.sv
// Avalon-MM streaming master for the SDRAM controller: record writes an input
// sample stream to consecutive words, playback issues pipelined reads into an output FIFO.
module sdram_stream_master #(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [1:0]        m_byteenable_n,
    output logic              m_chipselect,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read_n,
    output logic              m_write_n,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REC, S_PLAY, S_DRAIN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, remaining_q, remaining_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_q, req_d, wr_q, wr_d, aborted_q, aborted_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic accept, req_free, sample_acc, rd_issue, push, pop, flush;

    // req_q is the single pending request; it is held on the bus until accepted.
    assign accept     = req_q && !m_waitrequest;
    assign req_free   = !req_q || accept;
    assign sample_acc = in_valid && in_ready;
    assign push       = m_readdatavalid && (state_q == S_PLAY || state_q == S_DRAIN);
    assign pop        = out_valid && out_ready;
    assign flush      = (state_q == S_DRAIN) && (outst_q == '0) && aborted_q;

    // The pending read counts as in flight, so outstanding+fifo never exceeds FIFO_DEPTH.
    always_comb begin
        int inflight;
        inflight = 32'(outst_q) + 32'(req_q);
        rd_issue = (state_q == S_PLAY) && req_free && (remaining_q != '0) && !abort &&
                   (inflight < MAX_OUTSTANDING) &&
                   (inflight + 32'(fifo_cnt_q) < FIFO_DEPTH);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            aborted_q   <= 1'b0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            aborted_q   <= aborted_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= m_readdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) begin
                         if (length == '0) state_d = S_FIN;
                         else              state_d = mode ? S_PLAY : S_REC;
                     end
            S_REC:   if (req_free && (remaining_q == '0 || abort)) state_d = S_FIN;
            S_PLAY:  if (req_free && (remaining_q == '0 || abort)) state_d = S_DRAIN;
            S_DRAIN: if (outst_q == '0 && (aborted_q || fifo_cnt_q == '0)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        wr_d        = wr_q;
        aborted_d   = aborted_q;
        outst_d     = outst_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (state_q == S_IDLE && start) begin
            addr_d      = base_addr;
            remaining_d = length;
            aborted_d   = 1'b0;
        end
        if (((state_q == S_REC || state_q == S_PLAY) && req_free && abort) ||
            (state_q == S_DRAIN && abort))
            aborted_d = 1'b1;

        if (accept) begin
            req_d  = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
        end
        if (sample_acc) begin
            req_d       = 1'b1;
            wr_d        = 1'b1;
            wdata_d     = in_data;
            remaining_d = remaining_q - ADDR_W'(1);
        end else if (rd_issue) begin
            req_d       = 1'b1;
            wr_d        = 1'b0;
            remaining_d = remaining_q - ADDR_W'(1);
        end

        case ({accept && !wr_q, m_readdatavalid && outst_q != '0})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_FIN);
        aborted        = (state_q == S_FIN) && aborted_q;
        in_ready       = (state_q == S_REC) && (remaining_q != '0) && !abort && req_free;
        m_chipselect   = req_q;
        m_read_n       = !(req_q && !wr_q);
        m_write_n      = !(req_q && wr_q);
        m_byteenable_n = req_q ? 2'b00 : 2'b11;
        m_address      = addr_q;
        m_writedata    = wdata_q;
        out_valid      = (fifo_cnt_q != '0);
        out_data       = fifo_mem_q[rd_ptr_q];
    end
endmodule

// File: tb/tb_sdram_stream_master.sv
// Bench for sdram_stream_master: Avalon slave model with programmable stall and read
// latency, sample source, and scoreboard queues for writes and playback words.
module tb_sdram_stream_master;
    localparam int AW = 25;
    localparam int DW = 16;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic [AW-1:0] base_addr = '0, length = '0;
    logic          busy, done, aborted;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready = 1'b0;
    logic [AW-1:0] m_address;
    logic [1:0]    m_byteenable_n;
    logic          m_chipselect, m_read_n, m_write_n;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata = '0;
    logic          m_readdatavalid = 1'b0, m_waitrequest = 1'b0;

    sdram_stream_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4), .FIFO_DEPTH(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .mode(mode),
        .abort(abort), .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .aborted(aborted), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .m_address(m_address), .m_byteenable_n(m_byteenable_n), .m_chipselect(m_chipselect),
        .m_writedata(m_writedata), .m_read_n(m_read_n), .m_write_n(m_write_n),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct { int due; logic [DW-1:0] d; } resp_t;

    int            n_tests = 0, n_fail = 0;
    int            cyc = 0, lat = 5;
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] exp_out[$];
    resp_t         rq[$];
    int            req_idx, stall_idx, stall_len, stall_cnt;
    bit            holding;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    int            reads_acc, writes_acc, inflight, max_inflight, fifo_lvl, pops;
    int            done_cnt = 0, pops_at_done, strobe_cycles, first_wr_cyc, last_wr_cyc;
    bit            last_aborted;
    int            sidx, src_n;
    logic [DW-1:0] src_base;
    bit            src_on, take;

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5AA5;
    endfunction

    // Slave model at negedge (drives waitrequest/readdatavalid for the next posedge),
    // then the output-side monitor once combinational outputs have settled.
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            m_waitrequest   = 1'b0;
            m_readdatavalid = 1'b0;
        end else begin
            cyc++;
            m_readdatavalid = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_readdatavalid = 1'b1;
                m_readdata      = rq[0].d;
                void'(rq.pop_front());
                inflight--;
                fifo_lvl++;
            end
            m_waitrequest = 1'b0;
            if (m_chipselect) begin
                strobe_cycles++;
                n_tests++;
                if (m_read_n == m_write_n || m_byteenable_n !== 2'b00) begin
                    n_fail++;
                    $display("FAIL req_signals: read_n=%b write_n=%b be_n=%b", m_read_n, m_write_n, m_byteenable_n);
                end
                if (holding) begin
                    n_tests++;
                    if (m_address !== hold_a || m_writedata !== hold_d) begin
                        n_fail++;
                        $display("FAIL hold_stable: got %h/%h want %h/%h", m_address, m_writedata, hold_a, hold_d);
                    end
                end
                if (req_idx == stall_idx && stall_cnt < stall_len) begin
                    hold_a = m_address; hold_d = m_writedata; holding = 1'b1;
                    m_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    holding = 1'b0;
                    req_idx++;
                    if (!m_write_n) begin
                        writes_acc++;
                        if (writes_acc == 1) first_wr_cyc = cyc;
                        last_wr_cyc = cyc;
                        n_tests++;
                        if (exp_wa.size() == 0) begin
                            n_fail++;
                            $display("FAIL write_extra: got %h/%h want none", m_address, m_writedata);
                        end else begin
                            if (m_address !== exp_wa[0] || m_writedata !== exp_wd[0]) begin
                                n_fail++;
                                $display("FAIL write_data: got %h/%h want %h/%h", m_address, m_writedata, exp_wa[0], exp_wd[0]);
                            end
                            void'(exp_wa.pop_front());
                            void'(exp_wd.pop_front());
                        end
                    end else begin
                        reads_acc++;
                        inflight++;
                        if (inflight > max_inflight) max_inflight = inflight;
                        rq.push_back('{cyc + lat, rdata(m_address)});
                    end
                end
            end
            #1;
            if (m_waitrequest) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
            end
            take = in_valid && in_ready;
            if (out_valid && out_ready) begin
                pops++;
                fifo_lvl--;
                n_tests++;
                if (exp_out.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_extra: got %h want none", out_data);
                end else begin
                    if (out_data !== exp_out[0]) begin
                        n_fail++;
                        $display("FAIL pop_data: got %h want %h", out_data, exp_out[0]);
                    end
                    void'(exp_out.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                last_aborted = aborted;
                pops_at_done = pops;
            end
        end
    end

    always @(posedge clk_clk) begin
        #1;
        if (take) begin sidx++; take = 1'b0; end
        if (src_on) begin
            in_valid = (sidx < src_n);
            in_data  = src_base + 16'(sidx);
        end else in_valid = 1'b0;
    end

    task automatic tb_clear();
        exp_wa.delete(); exp_wd.delete(); exp_out.delete(); rq.delete();
        req_idx = 0; stall_idx = -1; stall_len = 0; stall_cnt = 0; holding = 1'b0;
        reads_acc = 0; writes_acc = 0; inflight = 0; max_inflight = 0; fifo_lvl = 0; pops = 0;
        strobe_cycles = 0; first_wr_cyc = 0; last_wr_cyc = 0;
        sidx = 0; src_n = 0; src_base = '0; src_on = 1'b0; take = 1'b0;
        in_valid = 1'b0; abort = 1'b0; lat = 5;
    endtask

    task automatic do_start(input logic m, input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk_clk); #1;
        mode = m; base_addr = b; length = n; start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc, output bit ok);
        for (int i = 0; i < maxc && done_cnt == d0; i++) @(posedge clk_clk);
        #1;
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        logic [50:0] got, exp;
        repeat (3) @(posedge clk_clk);
        #1;
        got = {m_chipselect, m_read_n, m_write_n, m_byteenable_n, m_address, m_writedata,
               in_ready, out_valid, busy, done, aborted};
        exp = {1'b0, 1'b1, 1'b1, 2'b11, 25'd0, 16'd0, 5'b00000};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_values: got %h want %h", got, exp); end
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
    endtask

    task automatic test_record(input logic [AW-1:0] base, input int n, input logic [DW-1:0] sb,
                               input int sidx_stall, input int slen);
        bit ok; int d0;
        tb_clear();
        out_ready = 1'b1;
        stall_idx = sidx_stall; stall_len = slen;
        for (int i = 0; i < n; i++) begin
            exp_wa.push_back(AW'(base + AW'(i)));
            exp_wd.push_back(sb + 16'(i));
        end
        src_base = sb; src_n = n; src_on = 1'b1;
        d0 = done_cnt;
        do_start(1'b0, base, AW'(n));
        wait_done(d0, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rec_done: got none want done"); end
        n_tests++; if (last_aborted !== 1'b0) begin n_fail++; $display("FAIL rec_aborted: got %b want 0", last_aborted); end
        n_tests++; if (writes_acc !== n) begin n_fail++; $display("FAIL rec_writes: got %0d want %0d", writes_acc, n); end
        n_tests++; if (exp_wa.size() !== 0) begin n_fail++; $display("FAIL rec_missing: got %0d left want 0", exp_wa.size()); end
        n_tests++; if (sidx !== n) begin n_fail++; $display("FAIL rec_samples: got %0d want %0d", sidx, n); end
        n_tests++;
        if (last_wr_cyc - first_wr_cyc !== n - 1 + stall_cnt) begin
            n_fail++; $display("FAIL rec_spacing: got %0d want %0d", last_wr_cyc - first_wr_cyc, n - 1 + stall_cnt);
        end
        n_tests++; if (stall_cnt !== slen) begin n_fail++; $display("FAIL rec_stall: got %0d want %0d", stall_cnt, slen); end
        src_on = 1'b0;
    endtask

    task automatic test_playback();
        bit ok; int d0;
        tb_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_out.push_back(rdata(AW'(25'h100 + i)));
        d0 = done_cnt;
        do_start(1'b1, 25'h100, 25'd6);
        wait_done(d0, 200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL play_done: got none want done"); end
        n_tests++; if (last_aborted !== 1'b0) begin n_fail++; $display("FAIL play_aborted: got %b want 0", last_aborted); end
        n_tests++; if (pops_at_done !== 6) begin n_fail++; $display("FAIL play_pops_at_done: got %0d want 6", pops_at_done); end
        n_tests++; if (max_inflight !== 4) begin n_fail++; $display("FAIL play_max_inflight: got %0d want 4", max_inflight); end
        n_tests++; if (reads_acc !== 6) begin n_fail++; $display("FAIL play_reads: got %0d want 6", reads_acc); end
    endtask

    task automatic test_fifo_full();
        bit ok; int d0;
        tb_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) exp_out.push_back(rdata(AW'(25'h200 + i)));
        d0 = done_cnt;
        do_start(1'b1, 25'h200, 25'd12);
        repeat (40) @(posedge clk_clk);
        #1;
        n_tests++; if (reads_acc !== 8) begin n_fail++; $display("FAIL full_reads: got %0d want 8", reads_acc); end
        n_tests++; if (fifo_lvl !== 8) begin n_fail++; $display("FAIL full_level: got %0d want 8", fifo_lvl); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        wait_done(d0, 300, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL full_done: got none want done"); end
        n_tests++; if (reads_acc !== 12) begin n_fail++; $display("FAIL full_reads_total: got %0d want 12", reads_acc); end
        n_tests++; if (pops !== 12) begin n_fail++; $display("FAIL full_pops: got %0d want 12", pops); end
        n_tests++; if (max_inflight > 4) begin n_fail++; $display("FAIL full_max_inflight: got %0d want <=4", max_inflight); end
    endtask

    task automatic test_abort();
        bit ok, hit; int d0;
        tb_clear();
        out_ready = 1'b0;
        d0 = done_cnt;
        do_start(1'b1, 25'h300, 25'd20);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk_clk); #2;
            hit = (reads_acc >= 3);
        end
        abort = 1'b1;
        wait_done(d0, 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_done: got none want done"); end
        n_tests++; if (last_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b want 1", last_aborted); end
        n_tests++; if (reads_acc !== 3) begin n_fail++; $display("FAIL abort_reads: got %0d want 3", reads_acc); end
        n_tests++; if (inflight !== 0 || rq.size() !== 0) begin n_fail++; $display("FAIL abort_absorb: got %0d want 0", inflight); end
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_flush: got %b%b want 00", out_valid, busy); end
        abort = 1'b0;
    endtask

    task automatic test_len0();
        tb_clear();
        @(posedge clk_clk); #1;
        mode = 1'b0; base_addr = '0; length = '0; start = 1'b1;
        @(posedge clk_clk); #1;
        n_tests++; if ({done, busy} !== 2'b11) begin n_fail++; $display("FAIL len0_done: got %b want 11", {done, busy}); end
        @(posedge clk_clk); #1;
        start = 1'b0;
        n_tests++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL len0_fin_start: got %b want 00", {done, busy}); end
        @(posedge clk_clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got %b want 0", busy); end
        n_tests++; if (strobe_cycles !== 0) begin n_fail++; $display("FAIL len0_strobes: got %0d want 0", strobe_cycles); end
    endtask

    task automatic test_reset_mid_write();
        bit hit;
        logic [50:0] got, exp;
        tb_clear();
        stall_idx = 0; stall_len = 30;
        src_base = 16'hC001; src_n = 4; src_on = 1'b1;
        do_start(1'b0, 25'h40, 25'd4);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk_clk); #2;
            hit = (m_chipselect === 1'b1 && m_write_n === 1'b0);
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_write_seen: got none want write"); end
        reset_reset_n = 1'b0;
        #1;
        got = {m_chipselect, m_read_n, m_write_n, m_byteenable_n, m_address, m_writedata,
               in_ready, out_valid, busy, done, aborted};
        exp = {1'b0, 1'b1, 1'b1, 2'b11, 25'd0, 16'd0, 5'b00000};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_mid_write: got %h want %h", got, exp); end
        @(posedge clk_clk); #1;
        tb_clear();
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        n_tests++; if (busy !== 1'b0 || m_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b%b want 00", busy, m_chipselect); end
    endtask

    initial begin
        tb_clear();
        test_reset();
        test_record(25'h10, 4, 16'hA001, -1, 0);
        test_record(25'h10, 4, 16'hA001, 1, 3);
        test_playback();
        test_fifo_full();
        test_record(25'h1FFFFFE, 3, 16'hB001, -1, 0);
        test_abort();
        test_len0();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_stream_master.md
Name: sdram_stream_master

Overview:
- Avalon-MM master that drives the SDRAM controller's 16-bit slave interface (address, byteenable_n, chipselect, read_n/write_n, waitrequest, readdatavalid).
- Record mode: writes an incoming DRFM sample stream to consecutive SDRAM words.
- Playback mode: issues pipelined reads and returns the words as an output sample stream.
- Sits between the DRFM datapath and the SDRAM subsystem.

Parameters:
ADDR_W, 25, word-address width of the SDRAM interface
DATA_W, 16, sample/word width
MAX_OUTSTANDING, 4, maximum in-flight read requests
FIFO_DEPTH, 8, playback output FIFO depth; power of two, >= MAX_OUTSTANDING

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins an operation; ignored while busy=1
mode  in  1  0=record, 1=playback; sampled on start
abort  in  1  level; stops issuing new requests
base_addr  in  ADDR_W  first word address; sampled on start
length  in  ADDR_W  number of words; sampled on start
busy  out  1  operation in progress
done  out  1  one-cycle pulse at operation end
aborted  out  1  valid with done; 1 if the operation ended by abort
in_data  in  DATA_W  record sample
in_valid  in  1  record sample valid
in_ready  out  1  record sample accepted when in_valid&in_ready
out_data  out  DATA_W  playback sample, first-word-fall-through
out_valid  out  1  playback FIFO non-empty
out_ready  in  1  consumer pops on out_valid&out_ready
m_address  out  ADDR_W  Avalon word address
m_byteenable_n  out  2  active-low byte enables
m_chipselect  out  1  request active
m_writedata  out  DATA_W  write data
m_read_n  out  1  active-low read strobe
m_write_n  out  1  active-low write strobe
m_readdata  in  DATA_W  read data
m_readdatavalid  in  1  read data valid; responses return in order
m_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, active-low) values: m_chipselect=0, m_read_n=1, m_write_n=1, m_byteenable_n=2'b11, m_address=0, m_writedata=0, in_ready=0, out_valid=0, busy=0, done=0, aborted=0. Reset also clears the FIFO, the counters and any pending request, and returns the FSM to IDLE.
- Avalon rule: a request is accepted in any cycle where chipselect=1, a strobe is low and waitrequest=0. While waitrequest=1, address, data, strobes and byteenable_n are held stable.
- During any request, m_byteenable_n=2'b00. m_chipselect is asserted only together with a strobe.
- The address register loads base_addr on start and increments by 1 per accepted request, wrapping modulo 2^ADDR_W.
- FSM IDLE: on start, latch mode, base_addr and length, then go to REC or PLAY. If length=0, go to FIN and issue no transfers.
- FSM REC:
  - in_ready = 1 when remaining>0, !abort, and no request is pending or the pending request is accepted this cycle.
  - An accepted sample drives m_write_n=0 and m_writedata=in_data on the next cycle. A new request may follow an accepted one back-to-back, giving one write per cycle at zero wait.
  - Exit to FIN when remaining reaches 0, or when abort=1, after the pending write is accepted.
- FSM PLAY:
  - A read is issued when remaining>0, !abort, outstanding<MAX_OUTSTANDING and outstanding+fifo_count<FIFO_DEPTH. This credit rule makes FIFO overflow impossible.
  - outstanding increments on read accept and decrements on m_readdatavalid. When both occur in the same cycle, outstanding is unchanged.
  - Each m_readdatavalid pushes m_readdata into the FIFO. A push and a pop in the same cycle keep the count unchanged.
  - After the last read is accepted, or on abort once the pending read is accepted, go to DRAIN.
- FSM DRAIN: wait for outstanding=0 and the FIFO empty, then go to FIN. On abort, the FIFO is flushed once outstanding=0.
- FSM FIN: done=1 for one cycle; aborted=1 if abort caused the exit; busy=0 next cycle; return to IDLE.
- busy=1 in every state except IDLE.
- A start arriving in the FIN cycle is ignored.

Test Plan:
- Record, base=0x000010, length=4, waitrequest=0, in_valid constant, samples 0xA001..0xA004 -> four writes on consecutive cycles to 0x10..0x13 with matching data, byteenable_n=00, then done=1, aborted=0.
- Record, waitrequest held high 3 cycles on the second write -> address 0x11 and data 0xA002 held stable for all 3 cycles, in_ready=0 during the stall, no sample lost or duplicated.
- Playback, length=6, readdatavalid 5 cycles after each accept, out_ready=1 -> never more than 4 reads in flight, out_data appears in address order, done only after the 6th word pops.
- Playback with out_ready=0 -> issuing stops once outstanding+fifo_count=8, the FIFO fills to 8 with no overflow, and reads resume as out_ready pops words.
- Address wrap: base=0x1FFFFFE, length=3 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
- Abort mid-playback with 3 reads outstanding -> no new reads issued, all 3 responses absorbed, FIFO flushed, done=1 and aborted=1. Separately, length=0 -> done the cycle after IDLE with no strobes, and asserting reset_reset_n=0 mid-write returns all outputs to reset values immediately.
